heading_detector: RTL and testbench

Tracks the direction of travel of the ball in the ball-and-paddle game. It registers the previous ball position each clock and compares it with the current position. It outputs one sticky heading bit per axis for the collision/bounce logic and the paddle AI. It sits between the ball-position generator and any logic that needs to know which way the ball is moving.

---
 rtl/heading_detector.sv | 101 ++++++++++
 tb/tb_heading_detector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/heading_detector.sv
// heading_detector: tracks the ball's direction of travel on each axis.
// A one-sample history of the ball position is compared with the current
// position each clock. Small moves update a sticky per-axis heading bit.
// Moves larger than MAX_STEP are treated as respawns and leave the heading
// unchanged.
// Optional feature macro: HEADING_FLIP_EN adds the x_flip/y_flip pulse
// outputs, which go high for one cycle after a heading change.
// This block has no handshake: bx/by are sampled on every rising edge and
// xh/yh are always valid.
module heading_detector #(
  parameter int       COORD_W  = 11,
  parameter logic     XH_RST   = 1'b1,
  parameter logic     YH_RST   = 1'b1,
  parameter int       MAX_STEP = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               xh,
  output logic               yh
`ifdef HEADING_FLIP_EN
  ,
  output logic               x_flip,
  output logic               y_flip
`endif
);

  // The step limit uses the same width as the differences, so the
  // comparison cannot overflow.
  localparam logic [COORD_W:0] STEP_LIM = (COORD_W+1)'(MAX_STEP);

  logic [COORD_W-1:0] prev_x;
  logic [COORD_W-1:0] prev_y;
  logic               prev_valid;

  logic [COORD_W:0]   dx_up;
  logic [COORD_W:0]   dx_dn;
  logic [COORD_W:0]   dy_up;
  logic [COORD_W:0]   dy_dn;
  logic               xh_next;
  logic               yh_next;

  // The differences are one bit wider than the coordinates, so a move from
  // 0 to the maximum coordinate counts as a large jump and does not wrap.
  always_comb begin
    dx_up = {1'b0, bx} - {1'b0, prev_x};
    dx_dn = {1'b0, prev_x} - {1'b0, bx};
    dy_up = {1'b0, by} - {1'b0, prev_y};
    dy_dn = {1'b0, prev_y} - {1'b0, by};
  end

  // Next heading per axis: hold unless a small, real move is seen.
  always_comb begin
    xh_next = xh;
    yh_next = yh;
    if (prev_valid) begin
      if ((bx > prev_x) && (dx_up <= STEP_LIM)) begin
        xh_next = 1'b1;
      end else if ((bx < prev_x) && (dx_dn <= STEP_LIM)) begin
        xh_next = 1'b0;
      end
      if ((by > prev_y) && (dy_up <= STEP_LIM)) begin
        yh_next = 1'b1;
      end else if ((by < prev_y) && (dy_dn <= STEP_LIM)) begin
        yh_next = 1'b0;
      end
    end
  end

  // Position history and the registered headings.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      xh         <= XH_RST;
      yh         <= YH_RST;
    end else begin
      prev_x     <= bx;
      prev_y     <= by;
      prev_valid <= 1'b1;
      xh         <= xh_next;
      yh         <= yh_next;
    end
  end

`ifdef HEADING_FLIP_EN
  // Flip pulses are registered alongside the heading they report on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_flip <= 1'b0;
      y_flip <= 1'b0;
    end else begin
      x_flip <= (xh_next != xh);
      y_flip <= (yh_next != yh);
    end
  end
`endif

endmodule

// File: tb/tb_heading_detector.sv
// tb_heading_detector: directed test of heading_detector. It covers reset,
// forward and reverse motion, holds, the MAX_STEP boundary, respawn jumps,
// the 0 -> max coordinate wrap case, and a mid-run asynchronous reset.
// The flip outputs are checked when HEADING_FLIP_EN is defined.
module tb_heading_detector;

  localparam int COORD_W = 11;

  logic               clk;
  logic               rst;
  logic [COORD_W-1:0] bx;
  logic [COORD_W-1:0] by;
  logic               xh;
  logic               yh;
`ifdef HEADING_FLIP_EN
  logic               x_flip;
  logic               y_flip;
`endif

  int n_checks;
  int n_fail;

  heading_detector #(
    .COORD_W (COORD_W),
    .XH_RST  (1'b1),
    .YH_RST  (1'b1),
    .MAX_STEP(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bx    (bx),
    .by    (by),
    .xh    (xh),
    .yh    (yh)
`ifdef HEADING_FLIP_EN
    ,
    .x_flip(x_flip),
    .y_flip(y_flip)
`endif
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports the observed and expected values on failure.
  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks both headings and, when present, both flip pulses.
  task automatic check_all(input string tag, input logic xe, input logic ye,
                           input logic xfe, input logic yfe);
    check({tag, " xh"}, xh, xe);
    check({tag, " yh"}, yh, ye);
`ifdef HEADING_FLIP_EN
    check({tag, " x_flip"}, x_flip, xfe);
    check({tag, " y_flip"}, y_flip, yfe);
`else
    if (xfe || yfe) begin end
`endif
  endtask

  // Drives a position before the next rising edge. Returns on the following falling edge.
  task automatic step(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    bx = x;
    by = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bx  = 11'd60;
    by  = 11'd60;

    // Reset held: default headings, no flips.
    repeat (3) @(negedge clk);
    check_all("reset_hold", 1'b1, 1'b1, 1'b0, 1'b0);

    // First edge after release only loads the history.
    rst = 1'b1;
    step(11'd60, 11'd60);
    check_all("first_edge", 1'b1, 1'b1, 1'b0, 1'b0);

    // Diagonal forward.
    step(11'd61, 11'd61);
    check_all("fwd1", 1'b1, 1'b1, 1'b0, 1'b0);
    step(11'd62, 11'd62);
    check_all("fwd2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Per-axis reversal.
    step(11'd61, 11'd62);
    check_all("rev_x", 1'b0, 1'b1, 1'b1, 1'b0);
    step(11'd62, 11'd61);
    check_all("rev_both_axes", 1'b1, 1'b0, 1'b1, 1'b1);

    // Hold for 10 cycles: headings hold and no flips occur.
    for (int i = 0; i < 10; i++) begin
      step(11'd62, 11'd61);
      check_all("hold", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reverse both axes.
    step(11'd61, 11'd60);
    check_all("back1", 1'b0, 1'b0, 1'b1, 1'b0);
    step(11'd60, 11'd59);
    check_all("back2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Respawn: a large jump leaves the headings unchanged.
    step(11'd400, 11'd300);
    check_all("respawn", 1'b0, 1'b0, 1'b0, 1'b0);

    // Motion after a respawn is measured from the new position.
    step(11'd401, 11'd301);
    check_all("post_respawn", 1'b1, 1'b1, 1'b1, 1'b1);

    // Boundary: a step of exactly -16 counts as motion; +17 on y is a respawn.
    step(11'd385, 11'd318);
    check_all("step_16_17", 1'b0, 1'b1, 1'b1, 1'b0);

    // Boundary: +16 on x counts as motion; -17 on y is a respawn.
    step(11'd401, 11'd301);
    check_all("step_p16_m17", 1'b1, 1'b1, 1'b1, 1'b0);

    // Steps of 1 move the heading to decreasing on both axes.
    step(11'd400, 11'd300);
    check_all("down1", 1'b0, 1'b0, 1'b1, 1'b1);

    // Jump to 0 on x is a respawn; y holds.
    step(11'd0, 11'd300);
    check_all("jump_to_0", 1'b0, 1'b0, 1'b0, 1'b0);

    // 0 -> 2047 is a large positive delta, not a wrap to -1: xh holds.
    step(11'd2047, 11'd300);
    check_all("wrap_0_to_max", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2047 -> 0 is likewise a respawn.
    step(11'd0, 11'd301);
    check_all("wrap_max_to_0", 1'b0, 1'b1, 1'b0, 1'b1);
    step(11'd0, 11'd300);
    check_all("pre_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-run reset: outputs return to their defaults immediately.
    #2 rst = 1'b0;
    #1;
    check_all("async_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // After release, the first edge is a fresh first sample.
    step(11'd100, 11'd100);
    check_all("reset_first", 1'b1, 1'b1, 1'b0, 1'b0);
    step(11'd99, 11'd101);
    check_all("reset_move", 1'b0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
